// File: rtl/boot_ram_arb_pkg.sv
// Shared definitions for the boot RAM arbiter: response-owner encoding,
// default geometry and the out-of-range address mask.
package boot_ram_arb_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned MASK_W     = 64;

  typedef enum logic [2:0] {
    OWN_NONE     = 3'd0,
    OWN_INSTR    = 3'd1,
    OWN_DATA_RD  = 3'd2,
    OWN_DATA_WR  = 3'd3,
    OWN_DATA_ERR = 3'd4
  } owner_e;

  // Set bits mark byte-address bits above the RAM word range.
  function automatic logic [MASK_W-1:0] oob_mask(
    input int unsigned aw
  );
    logic [MASK_W-1:0] m;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i >= int'(aw + 2));
    end
    return m;
  endfunction

  localparam logic [MASK_W-1:0] RANGE_MASK = oob_mask(ADDR_W_DEF);

endpackage

// File: rtl/boot_ram_arbiter_if.sv
// Bus bundle between fetch/LSU requesters, the arbiter and the boot RAM.
// slave: arbiter side. master: requesters plus RAM macro side.
interface boot_ram_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 9
);

  logic              instr_req;
  logic [XLEN-1:0]   instr_addr;
  logic              instr_gnt;
  logic              instr_rvalid;
  logic [XLEN-1:0]   instr;

  logic              data_req;
  logic              data_we;
  logic [3:0]        data_be;
  logic [XLEN-1:0]   data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [XLEN-1:0]   data_rdata;
  logic              data_err;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   ram_rdata;

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr,
    input  data_req, data_we, data_be,
    input  data_addr, data_wdata,
    output data_gnt, data_rvalid,
    output data_rdata, data_err,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr,
    output data_req, data_we, data_be,
    output data_addr, data_wdata,
    input  data_gnt, data_rvalid,
    input  data_rdata, data_err,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/boot_ram_arb_fair.sv
// Anti-starvation counter: after STARVE_MAX data grants while fetch waits,
// fetch wins the next conflict. Ports: clk, rst, req/gnt in, o_fetch_prio.
module boot_ram_arb_fair #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_instr_req,
  input  logic i_instr_gnt,
  input  logic i_data_gnt,
  output logic o_fetch_prio
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_instr_req || i_instr_gnt) begin
      r_cnt <= '0;
    end else if (i_data_gnt) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_fetch_prio =
    i_instr_req && (r_cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/boot_ram_arbiter.sv
// Arbitrates fetch and LSU onto one single-port boot RAM (1-cycle read).
// Ports: clk, rst (sync, active-high), bus (boot_ram_arbiter_if.slave).
// Optional: define ARB_FAIRNESS_EN to bound fetch starvation.
module boot_ram_arbiter
  import boot_ram_arb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  boot_ram_arbiter_if.slave bus
);

  localparam logic [MASK_W-1:0] LP_MASK = oob_mask(ADDR_W);
  localparam logic [XLEN-1:0]   LP_OOB  = LP_MASK[XLEN-1:0];

  owner_e r_owner;
  owner_e w_owner_nxt;

  logic w_fetch_prio;
  logic w_data_gnt;
  logic w_instr_gnt;
  logic w_oob;

`ifdef ARB_FAIRNESS_EN
  boot_ram_arb_fair #(
    .STARVE_MAX (STARVE_MAX)
  ) u_fair (
    .clk          (clk),
    .rst          (rst),
    .i_instr_req  (bus.instr_req),
    .i_instr_gnt  (w_instr_gnt),
    .i_data_gnt   (w_data_gnt),
    .o_fetch_prio (w_fetch_prio)
  );
`else
  localparam int unsigned LP_UNUSED_STARVE = STARVE_MAX;
  assign w_fetch_prio = 1'b0;
`endif

  // No new access is started while reset is held.
  assign w_data_gnt  = !rst && bus.data_req && !w_fetch_prio;
  assign w_instr_gnt = !rst && bus.instr_req && !w_data_gnt;
  assign w_oob       = |(bus.data_addr & LP_OOB);

  assign bus.instr_gnt = w_instr_gnt;
  assign bus.data_gnt  = w_data_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_owner_nxt   = OWN_NONE;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 4'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    unique case (1'b1)
      (w_data_gnt && w_oob): begin
        w_owner_nxt = OWN_DATA_ERR;
      end
      (w_data_gnt && !w_oob && bus.data_we): begin
        w_owner_nxt   = OWN_DATA_WR;
        bus.ram_en    = 1'b1;
        bus.ram_we    = bus.data_be;
        bus.ram_addr  = bus.data_addr[ADDR_W+1:2];
        bus.ram_wdata = bus.data_wdata;
      end
      (w_data_gnt && !w_oob && !bus.data_we): begin
        w_owner_nxt  = OWN_DATA_RD;
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.data_addr[ADDR_W+1:2];
      end
      w_instr_gnt: begin
        w_owner_nxt  = OWN_INSTR;
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.instr_addr[ADDR_W+1:2];
      end
      default: begin
      end
    endcase
  end

  // A response owed on a reset cycle is dropped.
  always_comb begin
    bus.instr_rvalid = 1'b0;
    bus.instr        = '0;
    bus.data_rvalid  = 1'b0;
    bus.data_rdata   = '0;
    bus.data_err     = 1'b0;
    if (!rst) begin
      unique case (r_owner)
        OWN_INSTR: begin
          bus.instr_rvalid = 1'b1;
          bus.instr        = bus.ram_rdata;
        end
        OWN_DATA_RD: begin
          bus.data_rvalid = 1'b1;
          bus.data_rdata  = bus.ram_rdata;
        end
        OWN_DATA_WR: begin
          bus.data_rvalid = 1'b1;
        end
        OWN_DATA_ERR: begin
          bus.data_rvalid = 1'b1;
          bus.data_err    = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Fetch wraps modulo RAM size; sub-word bits are don't-care.
  logic w_unused_addr;
  assign w_unused_addr = ^{
    bus.instr_addr[XLEN-1:ADDR_W+2],
    bus.instr_addr[1:0],
    bus.data_addr[1:0]
  };

endmodule

// File: tb/tb_boot_ram_arbiter.sv
// Directed scoreboard bench for boot_ram_arbiter with a behavioural RAM.
// Expected responses are queued at grant and checked by a monitor.
module tb_boot_ram_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] d;
  } dresp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] q_i[$];
  dresp_t      q_d[$];
  logic [31:0] mem[512];

  boot_ram_arbiter_if #(.XLEN(32), .ADDR_W(9)) b ();

  boot_ram_arbiter #(
    .XLEN       (32),
    .ADDR_W     (9),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b.ram_en) begin
      if (b.ram_we != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (b.ram_we[k]) begin
            mem[b.ram_addr][k*8 +: 8] <= b.ram_wdata[k*8 +: 8];
          end
        end
      end else begin
        b.ram_rdata <= mem[b.ram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=unexpected want=none t=%0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (b.instr_rvalid) begin
      if (q_i.size() == 0) fail("instr_unexp");
      else chk("instr", b.instr, q_i.pop_front());
    end else begin
      chk("instr_gate", b.instr, 32'h0);
    end
    if (b.data_rvalid) begin
      if (q_d.size() == 0) begin
        fail("data_unexp");
      end else begin
        dresp_t e;
        e = q_d.pop_front();
        chk("data_rdata", b.data_rdata, e.d);
        chk("data_err", {31'b0, b.data_err}, {31'b0, e.err});
      end
    end else begin
      chk("rdata_gate", b.data_rdata, 32'h0);
    end
  end

  task automatic drv(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw,
                     input logic [3:0] be, input logic [31:0] da,
                     input logic [31:0] wd);
    b.instr_req  = ir;
    b.instr_addr = ia;
    b.data_req   = dr;
    b.data_we    = dw;
    b.data_be    = be;
    b.data_addr  = da;
    b.data_wdata = wd;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_chk(input string nm, input logic ig,
                         input logic dg, input logic en,
                         input logic [3:0] we, input logic [8:0] a);
    @(negedge clk);
    chk({nm, ".igt"}, {31'b0, b.instr_gnt}, {31'b0, ig});
    chk({nm, ".dgt"}, {31'b0, b.data_gnt}, {31'b0, dg});
    chk({nm, ".en"}, {31'b0, b.ram_en}, {31'b0, en});
    if (en) begin
      chk({nm, ".we"}, {28'b0, b.ram_we}, {28'b0, we});
      chk({nm, ".addr"}, {23'b0, b.ram_addr}, {23'b0, a});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fg;
    total = 0;
    bad   = 0;
    for (int k = 0; k < 512; k++) mem[k] = 32'h0;
    mem[4] = 32'h00500093;
    mem[5] = 32'h00a00113;
    mem[8] = 32'h12345678;
    b.ram_rdata = 32'h0;
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.igt", {31'b0, b.instr_gnt}, 32'h0);
    chk("rst.dgt", {31'b0, b.data_gnt}, 32'h0);
    chk("rst.irv", {31'b0, b.instr_rvalid}, 32'h0);
    chk("rst.drv", {31'b0, b.data_rvalid}, 32'h0);
    chk("rst.en", {31'b0, b.ram_en}, 32'h0);
    tick();

    drv(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_chk("fetch", 1'b1, 1'b0, 1'b1, 4'h0, 9'd4);
    q_i.push_back(32'h00500093);
    tick();
    idle();
    tick();

    drv(1'b1, 32'h14, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    bus_chk("conf1", 1'b0, 1'b1, 1'b1, 4'h0, 9'd8);
    q_d.push_back('{err: 1'b0, d: 32'h12345678});
    tick();
    drv(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_chk("conf2", 1'b1, 1'b0, 1'b1, 4'h0, 9'd5);
    q_i.push_back(32'h00a00113);
    tick();

    drv(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF);
    bus_chk("wr", 1'b0, 1'b1, 1'b1, 4'b0011, 9'd16);
    chk("wr.wdata", b.ram_wdata, 32'hDEADBEEF);
    q_d.push_back('{err: 1'b0, d: 32'h0});
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    bus_chk("rdback", 1'b0, 1'b1, 1'b1, 4'h0, 9'd16);
    q_d.push_back('{err: 1'b0, d: 32'h0000BEEF});
    tick();

    drv(1'b1, 32'h810, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_chk("wrap", 1'b1, 1'b0, 1'b1, 4'h0, 9'd4);
    q_i.push_back(32'h00500093);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h800, 32'h0);
    bus_chk("oob", 1'b0, 1'b1, 1'b0, 4'h0, 9'd0);
    q_d.push_back('{err: 1'b1, d: 32'h0});
    tick();
    drv(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_chk("alt", 1'b1, 1'b0, 1'b1, 4'h0, 9'd5);
    q_i.push_back(32'h00a00113);
    tick();
    idle();
    repeat (2) tick();

    drv(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_chk("inflt", 1'b1, 1'b0, 1'b1, 4'h0, 9'd4);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("inflt.irv", {31'b0, b.instr_rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post.irv", {31'b0, b.instr_rvalid}, 32'h0);
    chk("post.drv", {31'b0, b.data_rvalid}, 32'h0);
    chk("post.err", {31'b0, b.data_err}, 32'h0);
    chk("post.en", {31'b0, b.ram_en}, 32'h0);
    chk("post.we", {28'b0, b.ram_we}, 32'h0);
    tick();

    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
`ifdef ARB_FAIRNESS_EN
      fg = ((i % 5) == 4);
`else
      fg = 1'b0;
`endif
      bus_chk("starve", fg, !fg, 1'b1, 4'h0, fg ? 9'd4 : 9'd8);
      if (fg) q_i.push_back(32'h00500093);
      else q_d.push_back('{err: 1'b0, d: 32'h12345678});
      tick();
    end
    idle();
    repeat (3) tick();

    chk("drain_i", 32'(q_i.size()), 32'h0);
    chk("drain_d", 32'(q_d.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
